// File: rtl/imem_resp.sv
// Instruction-memory responder: synchronous ROM read stage feeding a
// 2-entry response FIFO with flush, misalignment/range flagging and a load port.
module imem_resp #(
    parameter logic [31:0] ROM_ORI    = 32'h0000_0000,
    parameter int          DEPTH_LOG2 = 10
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_valid_i,
    input  logic [31:0]           req_pc_i,
    output logic                  req_ready_o,
    input  logic                  flush_i,
    output logic                  rsp_valid_o,
    output logic [31:0]           rsp_pc_o,
    output logic [31:0]           rsp_inst_o,
    output logic                  rsp_err_o,
    input  logic                  rsp_ready_i,
    input  logic                  ld_we_i,
    input  logic [DEPTH_LOG2-1:0] ld_addr_i,
    input  logic [31:0]           ld_data_i
);

    localparam int          DEPTH = 1 << DEPTH_LOG2;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        err;
    } ent_t;

    logic [31:0] rom [DEPTH];

    logic [31:0]           off;
    logic [31:0]           idx_w;
    logic [DEPTH_LOG2-1:0] idx;
    logic                  req_err;

    assign off     = req_pc_i - ROM_ORI;
    assign idx_w   = off >> 2;
    assign idx     = idx_w[DEPTH_LOG2-1:0];
    assign req_err = (req_pc_i[1:0] != 2'b00) || ((idx_w >> DEPTH_LOG2) != 32'd0);

    logic        s1_v;
    logic [31:0] s1_pc;
    logic        s1_err;
    logic [31:0] s1_data;
    ent_t        s1_ent;

    ent_t       mem [2];
    logic       rd_ptr;
    logic       wr_ptr;
    logic [1:0] occ;

    ent_t       head;
    logic       pop;
    logic       acc;
    logic       fifo_push;
    logic       fifo_pop;
    logic [1:0] total;

    assign s1_ent.pc   = s1_pc;
    assign s1_ent.inst = s1_err ? NOP : s1_data;
    assign s1_ent.err  = s1_err;

    // An empty FIFO lets the read stage present its entry directly.
    assign head        = (occ != 2'd0) ? mem[rd_ptr] : s1_ent;
    assign rsp_valid_o = (occ != 2'd0) || s1_v;
    assign rsp_pc_o    = rsp_valid_o ? head.pc   : 32'd0;
    assign rsp_inst_o  = rsp_valid_o ? head.inst : 32'd0;
    assign rsp_err_o   = rsp_valid_o ? head.err  : 1'b0;

    assign pop   = rsp_valid_o && rsp_ready_i;
    assign total = occ + {1'b0, s1_v};

    assign req_ready_o = rst_ni && !flush_i && ((total < 2'd2) || pop);
    assign acc         = req_valid_i && req_ready_o;

    assign fifo_pop  = pop && (occ != 2'd0);
    assign fifo_push = s1_v && !(pop && (occ == 2'd0));

    // ROM and storage carry no reset: contents survive rst_ni.
    always_ff @(posedge clk_i) begin
        if (ld_we_i) begin
            rom[ld_addr_i] <= ld_data_i;
        end
        if (acc) begin
            s1_data <= rom[idx];
        end
        if (fifo_push) begin
            mem[wr_ptr] <= s1_ent;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_v   <= 1'b0;
            s1_pc  <= 32'd0;
            s1_err <= 1'b0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            occ    <= 2'd0;
        end else if (flush_i) begin
            s1_v   <= 1'b0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            occ    <= 2'd0;
        end else begin
            s1_v <= acc;
            if (acc) begin
                s1_pc  <= req_pc_i;
                s1_err <= req_err;
            end
            if (fifo_push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (fifo_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            occ <= occ + {1'b0, fifo_push} - {1'b0, fifo_pop};
        end
    end

endmodule

// File: tb/tb_imem_resp.sv
// Self-checking bench for imem_resp: directed sequences, a vector table
// and a randomized stream, all checked against a ROM model and scoreboard.
module tb_imem_resp;

    localparam int          DL  = 10;
    localparam logic [31:0] ORI = 32'h0000_0000;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic          clk;
    logic          rst_n;
    logic          req_valid;
    logic [31:0]   req_pc;
    logic          req_ready;
    logic          flush;
    logic          rsp_valid;
    logic [31:0]   rsp_pc;
    logic [31:0]   rsp_inst;
    logic          rsp_err;
    logic          rsp_ready;
    logic          ld_we;
    logic [DL-1:0] ld_addr;
    logic [31:0]   ld_data;

    imem_resp #(.ROM_ORI(ORI), .DEPTH_LOG2(DL)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .req_valid_i(req_valid),
        .req_pc_i   (req_pc),
        .req_ready_o(req_ready),
        .flush_i    (flush),
        .rsp_valid_o(rsp_valid),
        .rsp_pc_o   (rsp_pc),
        .rsp_inst_o (rsp_inst),
        .rsp_err_o  (rsp_err),
        .rsp_ready_i(rsp_ready),
        .ld_we_i    (ld_we),
        .ld_addr_i  (ld_addr),
        .ld_data_i  (ld_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        err;
    } exp_t;

    exp_t        sb [$];
    exp_t        tbl [7];
    logic [31:0] mrom [1 << DL];
    int          passed;
    int          total;
    logic        hold;
    logic [31:0] hpc;
    logic [31:0] hinst;
    logic        herr;

    task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, want %h", nm, act, exp);
    endtask

    function automatic logic [31:0] wd(input int i);
        return 32'h0010_0093 + (32'(i) << 20);
    endfunction

    function automatic exp_t model(input logic [31:0] pc);
        logic [31:0] i;
        exp_t e;
        i = (pc - ORI) >> 2;
        e.pc = pc;
        e.err = (pc[1:0] != 2'b00) || (i >= 32'(1 << DL));
        e.inst = e.err ? NOP : mrom[i[DL-1:0]];
        return e;
    endfunction

    // Entered at posedge+1 with inputs driven; returns at next posedge+1.
    task automatic tick(output bit acc);
        exp_t e;
        #2;
        if (hold) begin
            chk("stall_stable", {rsp_valid, rsp_err, rsp_pc, rsp_inst},
                {1'b1, herr, hpc, hinst});
        end
        acc = req_valid && req_ready;
        if (rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                total++;
                $display("FAIL unexpected_rsp: got pc %h, want no response", rsp_pc);
            end else begin
                e = sb.pop_front();
                chk("rsp", {rsp_pc, rsp_inst, 31'd0, rsp_err},
                    {e.pc, e.inst, 31'd0, e.err});
            end
        end
        if (acc) sb.push_back(model(req_pc));
        if (ld_we) mrom[ld_addr] = ld_data;
        if (flush) sb.delete();
        hold  = rsp_valid && !rsp_ready && !flush;
        hpc   = rsp_pc;
        hinst = rsp_inst;
        herr  = rsp_err;
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        bit a;
        tick(a);
    endtask

    task automatic req_until(input logic [31:0] pc);
        bit a;
        int n;
        req_valid = 1'b1;
        req_pc = pc;
        a = 1'b0;
        n = 0;
        while (!a && n < 10) begin
            tick(a);
            n++;
        end
        if (!a) begin
            total++;
            $display("FAIL req_timeout: got no accept, want accept of pc %h", pc);
        end
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        rsp_ready = 1'b1;
        req_valid = 1'b0;
        n = 0;
        while (sb.size() != 0 && n < 10) begin
            step();
            n++;
        end
        chk("drain_empty", 96'(sb.size()), 96'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit a;
        passed = 0;
        total = 0;
        hold = 1'b0;
        rst_n = 1'b0;
        req_valid = 1'b0;
        req_pc = 32'd0;
        flush = 1'b0;
        rsp_ready = 1'b0;
        ld_we = 1'b0;
        ld_addr = '0;
        ld_data = 32'd0;

        tbl[0] = '{32'h0000_0000, wd(0), 1'b0};
        tbl[1] = '{32'h0000_0004, wd(1), 1'b0};
        tbl[2] = '{32'h0000_0002, NOP, 1'b1};
        tbl[3] = '{32'h0000_1000, NOP, 1'b1};
        tbl[4] = '{32'h0000_003C, wd(15), 1'b0};
        tbl[5] = '{32'hFFFF_FFFC, NOP, 1'b1};
        tbl[6] = '{32'h0000_0001, NOP, 1'b1};

        #3;
        chk("reset_outputs", {rsp_valid, req_ready, rsp_err, rsp_pc, rsp_inst}, 96'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            ld_we = 1'b1;
            ld_addr = DL'(i);
            ld_data = wd(i);
            step();
        end
        ld_we = 1'b0;

        // single fetch, response next cycle
        rsp_ready = 1'b1;
        req_until(32'h0);
        chk("first_rsp", {rsp_valid, rsp_err, rsp_pc, rsp_inst},
            {1'b1, 1'b0, 32'h0, 32'h0010_0093});
        step();

        // back-to-back stream
        for (int i = 0; i < 4; i++) begin
            req_valid = 1'b1;
            req_pc = 32'(i * 4);
            #1;
            chk($sformatf("stream_ready_%0d", i), 96'(req_ready), 96'd1);
            if (i > 0) chk($sformatf("stream_valid_%0d", i), 96'(rsp_valid), 96'd1);
            tick(a);
        end
        req_valid = 1'b0;
        #1;
        chk("stream_valid_3", 96'(rsp_valid), 96'd1);
        step();
        chk("stream_done", 96'(sb.size()), 96'd0);

        // backpressure: only two accepted
        rsp_ready = 1'b0;
        req_until(32'h10);
        req_until(32'h14);
        req_valid = 1'b1;
        req_pc = 32'h18;
        #1;
        chk("full_ready_low", 96'(req_ready), 96'd0);
        tick(a);
        chk("full_no_accept", 96'(a), 96'd0);
        tick(a);
        chk("full_head", {rsp_valid, rsp_pc}, {1'b1, 32'h10});
        rsp_ready = 1'b1;
        for (int n = 0; n < 5 && !a; n++) tick(a);
        chk("third_accepted", 96'(a), 96'd1);
        drain();

        // vector table
        for (int k = 0; k < 7; k++) begin
            rsp_ready = 1'b1;
            req_until(tbl[k].pc);
            chk($sformatf("tbl_%0d", k), {rsp_valid, rsp_err, rsp_pc, rsp_inst},
                {1'b1, tbl[k].err, tbl[k].pc, tbl[k].inst});
            drain();
        end

        // flush with two pending
        rsp_ready = 1'b0;
        req_until(32'h20);
        req_until(32'h24);
        flush = 1'b1;
        step();
        flush = 1'b0;
        #1;
        chk("flush_empty", {rsp_valid, req_ready}, {1'b0, 1'b1});
        rsp_ready = 1'b1;
        step();
        step();
        rsp_ready = 1'b1;
        req_until(32'h8);
        chk("post_flush", {rsp_valid, rsp_pc, rsp_inst}, {1'b1, 32'h8, wd(2)});
        drain();

        // asynchronous reset with entries pending
        rsp_ready = 1'b0;
        req_until(32'h4);
        req_until(32'h8);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst", {rsp_valid, req_ready, rsp_err, rsp_pc, rsp_inst}, 96'd0);
        sb.delete();
        hold = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        req_until(32'h0);
        chk("rom_retained", {rsp_valid, rsp_inst}, {1'b1, 32'h0010_0093});
        drain();

        // randomized traffic with loads and flushes
        for (int n = 0; n < 400; n++) begin
            req_valid = ($urandom_range(0, 3) != 0);
            req_pc = ($urandom_range(0, 15) == 0) ? 32'($urandom_range(0, 63))
                                                 : 32'($urandom_range(0, 15) * 4);
            rsp_ready = ($urandom_range(0, 2) != 0);
            flush = ($urandom_range(0, 24) == 0);
            ld_we = ($urandom_range(0, 9) == 0);
            ld_addr = DL'($urandom_range(0, 15));
            ld_data = $urandom;
            step();
        end
        flush = 1'b0;
        ld_we = 1'b0;
        drain();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/imem_resp.md
IMEM_RESP -- requirements
Module: imem_resp

Interface
REQ-001 SHALL have parameter ROM_ORI, default 'h0_0000: byte address of ROM word 0.
REQ-002 SHALL have parameter DEPTH_LOG2, default 10: ROM holds 2**DEPTH_LOG2 32-bit words.
REQ-003 SHALL have port clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req_valid_i  input  1  fetch request valid.
REQ-006 SHALL have port req_pc_i  input  32  byte address of the requested instruction.
REQ-007 SHALL have port req_ready_o  output  1  request accepted when req_valid_i and req_ready_o are both 1 at a rising edge.
REQ-008 SHALL have port flush_i  input  1  redirect: discard all pending responses.
REQ-009 SHALL have port rsp_valid_o  output  1  response valid.
REQ-010 SHALL have port rsp_pc_o  output  32  PC of the response.
REQ-011 SHALL have port rsp_inst_o  output  32  instruction word.
REQ-012 SHALL have port rsp_err_o  output  1  request was misaligned or out of range.
REQ-013 SHALL have port rsp_ready_i  input  1  consumer accepts the response at the rising edge.
REQ-014 SHALL have ports ld_we_i (1), ld_addr_i (DEPTH_LOG2), ld_data_i (32), all inputs: ROM word load port.

Function
REQ-015 SHALL be a responder pipeline: 1-cycle synchronous ROM read stage, then a 2-entry output FIFO holding {pc, inst, err}.
REQ-016 SHALL compute index = (req_pc_i - ROM_ORI) >> 2, using 32-bit subtraction with wrap.
REQ-017 SHALL flag err when req_pc_i[1:0] != 0 or index >= 2**DEPTH_LOG2; an err entry carries inst 32'h0000_0013 (NOP).
REQ-018 SHALL make a request accepted at edge N visible at the FIFO head no earlier than edge N+1, giving rsp_valid_o = 1 in cycle N+1 when the FIFO was empty.
REQ-019 SHALL return responses in acceptance order, with rsp_pc_o equal to the accepted req_pc_i.
REQ-020 SHALL drive req_ready_o = !flush_i && ((occupancy + inflight) < 2 || (rsp_valid_o && rsp_ready_i)); combinational paths from rsp_ready_i are permitted, and zero bubbles occur at sustained full rate.
REQ-021 SHALL keep rsp_pc_o, rsp_inst_o and rsp_err_o stable while rsp_valid_o = 1 and rsp_ready_i = 0.
REQ-022 SHALL handle simultaneous pop and in-flight completion at occupancy 2 with no loss or duplication; occupancy never exceeds 2.
REQ-023 SHALL, on flush_i = 1 at an edge: clear the FIFO and the in-flight entry, accept no request, and drive rsp_valid_o = 0 in the next cycle.
REQ-024 SHALL, in a cycle with flush_i = 1, leave a response presented with rsp_ready_i = 1 counted as consumed by the consumer; internal state is discarded regardless.
REQ-025 SHALL write ld_data_i to ROM[ld_addr_i] at the edge when ld_we_i = 1.
REQ-026 SHALL use read-first behaviour: a read and a load to the same index in the same cycle returns the old word.
REQ-027 SHALL use occupancy encoding 0..2 and pointer wrap modulo 2.

Reset
REQ-028 SHALL, while rst_ni = 0, immediately force rsp_valid_o = 0, rsp_pc_o = 0, rsp_inst_o = 0, rsp_err_o = 0, occupancy = 0 and inflight = 0; req_ready_o is 0 while in reset.
REQ-029 SHALL leave ROM contents unaffected by reset.
REQ-030 SHALL discard pending responses when reset is asserted mid-operation and restart empty.
REQ-031 SHALL allow acceptance of requests from the first rising edge after rst_ni deasserts.

Verification
REQ-032 SHALL cover: load ROM[0] = 32'h0010_0093, request pc 0x0 with rsp_ready_i = 1 -> next cycle rsp_valid_o = 1, pc 0x0, inst 32'h0010_0093, err 0.
REQ-033 SHALL cover: stream pc 0x0, 0x4, 0x8, 0xC back-to-back with rsp_ready_i = 1 -> four responses in consecutive cycles, in order, req_ready_o held at 1.
REQ-034 SHALL cover: rsp_ready_i = 0 while issuing 3 requests -> only 2 accepted, req_ready_o = 0, outputs stable; raise rsp_ready_i -> both drain in order, then third is accepted.
REQ-035 SHALL cover: request pc 0x2, then pc 4 * 2**DEPTH_LOG2 -> both responses have err = 1, inst 32'h0000_0013.
REQ-036 SHALL cover: 2 entries pending, then pulse flush_i -> next cycle rsp_valid_o = 0 and neither old entry ever appears; a new request to pc 0x8 returns pc 0x8.
REQ-037 SHALL cover: assert rst_ni = 0 asynchronously between edges with entries pending -> rsp_valid_o falls before the next edge; ROM contents are retained after release.
